// File: rtl/serial_mag_comparator.sv
// ---------------------------------------------------------------------------
// serial_mag_comparator
//
// Bit-serial magnitude comparator. Operands A and B arrive MSB-first, one bit
// pair per bit_valid beat. After WIDTH beats, the block reports exactly one of
// lesser / greater / equal and pulses done for one cycle.
//
// The first differing bit pair decides the result. Any later bits are
// consumed only to keep the frame WIDTH beats long, and do not change it.
//
// Build option:
//   CMP_SIGNED_EN  when defined, operands are two's complement. A difference
//                  on the MSB beat is decided by the sign: B negative means
//                  A is greater. When undefined, the comparison is unsigned.
//
// Parameters:
//   WIDTH      operand width in bits (>=1); also the beat count per compare
//   CNT_W      beat counter width, derived from WIDTH
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous reset, active low
//   start      begin (or restart) a comparison, one-cycle pulse
//   bit_valid  a_bit/b_bit carry a valid bit pair this cycle
//   a_bit      operand A bit, MSB first
//   b_bit      operand B bit, MSB first
//   busy       high while collecting bits
//   done       one-cycle pulse when the result becomes valid
//   lesser     A < B   (held from done until the next start)
//   greater    A > B
//   equal      A == B
//   bits_left  beats remaining in the current comparison
// ---------------------------------------------------------------------------
module serial_mag_comparator #(
  parameter  int WIDTH = 3,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             bit_valid,
  input  logic             a_bit,
  input  logic             b_bit,
  output logic             busy,
  output logic             done,
  output logic             lesser,
  output logic             greater,
  output logic             equal,
  output logic [CNT_W-1:0] bits_left
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] bits_left_next;
  logic             decided;
  logic             decided_next;
  logic             gt_flag;
  logic             gt_flag_next;
  logic             lesser_next;
  logic             greater_next;
  logic             equal_next;

`ifdef CMP_SIGNED_EN
  // The MSB beat is the one taken while the counter is still full.
  logic first_beat;
  assign first_beat = (bits_left == CNT_W'(WIDTH));
`endif

  // State and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      bits_left <= '0;
      decided   <= 1'b0;
      gt_flag   <= 1'b0;
      lesser    <= 1'b0;
      greater   <= 1'b0;
      equal     <= 1'b0;
    end else begin
      state     <= state_next;
      bits_left <= bits_left_next;
      decided   <= decided_next;
      gt_flag   <= gt_flag_next;
      lesser    <= lesser_next;
      greater   <= greater_next;
      equal     <= equal_next;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_next     = state;
    bits_left_next = bits_left;
    decided_next   = decided;
    gt_flag_next   = gt_flag;
    lesser_next    = lesser;
    greater_next   = greater;
    equal_next     = equal;

    if (start) begin
      // Start from any state restarts the frame. The bit pair presented on
      // this same cycle is deliberately not consumed.
      state_next     = SHIFT;
      bits_left_next = CNT_W'(WIDTH);
      decided_next   = 1'b0;
      gt_flag_next   = 1'b0;
      lesser_next    = 1'b0;
      greater_next   = 1'b0;
      equal_next     = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state_next = IDLE;
        end

        SHIFT: begin
          if (bit_valid) begin
            bits_left_next = bits_left - 1'b1;

            if (!decided && (a_bit != b_bit)) begin
              decided_next = 1'b1;
`ifdef CMP_SIGNED_EN
              gt_flag_next = first_beat ? b_bit : a_bit;
`else
              gt_flag_next = a_bit;
`endif
            end

            // The last beat registers the result on the same edge. It uses
            // the *_next view so that a decision on this beat still counts.
            if (bits_left == CNT_W'(1)) begin
              state_next   = DONE;
              greater_next = decided_next & gt_flag_next;
              lesser_next  = decided_next & ~gt_flag_next;
              equal_next   = ~decided_next;
            end
          end
        end

        DONE: begin
          state_next = IDLE;
        end

        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_mag_comparator.sv
// ---------------------------------------------------------------------------
// tb_serial_mag_comparator
//
// Directed bench for serial_mag_comparator with WIDTH=3. Inputs are driven
// 1 time unit after the rising edge. Outputs are sampled 1 time unit after
// the edge that they result from. Expected values are hand-derived per step.
// ---------------------------------------------------------------------------
module tb_serial_mag_comparator;

  localparam int WIDTH = 3;
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             bit_valid;
  logic             a_bit;
  logic             b_bit;
  logic             busy;
  logic             done;
  logic             lesser;
  logic             greater;
  logic             equal;
  logic [CNT_W-1:0] bits_left;

  int n_cmp = 0;
  int n_bad = 0;

  serial_mag_comparator #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bit_valid (bit_valid),
    .a_bit     (a_bit),
    .b_bit     (b_bit),
    .busy      (busy),
    .done      (done),
    .lesser    (lesser),
    .greater   (greater),
    .equal     (equal),
    .bits_left (bits_left)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare {busy,done,lesser,greater,equal,bits_left} against expectations.
  task automatic expect_o(input string tag, input logic b, input logic d,
                          input logic l, input logic g, input logic e,
                          input int bl);
    logic [7:0] obs;
    logic [7:0] exp;
    obs = {1'b0, busy, done, lesser, greater, equal, bits_left};
    exp = {1'b0, b, d, l, g, e, bl[CNT_W-1:0]};
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed b/d/l/g/e/left=%b/%b/%b/%b/%b/%0d expected %b/%b/%b/%b/%b/%0d",
             tag, busy, done, lesser, greater, equal, bits_left, b, d, l, g, e, bl);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input logic a, input logic b);
    bit_valid = 1'b1;
    a_bit     = a;
    b_bit     = b;
    tick();
    bit_valid = 1'b0;
    a_bit     = 1'b0;
    b_bit     = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; bit_valid = 1'b0; a_bit = 1'b0; b_bit = 1'b0;
    tick(); tick();
    expect_o("reset", 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    tick();
    expect_o("idle_after_reset", 0, 0, 0, 0, 0, 0);

    // 1: 5 vs 5 -> equal
    pulse_start();
    expect_o("t1_start", 1, 0, 0, 0, 0, 3);
    beat(1, 1); expect_o("t1_b1", 1, 0, 0, 0, 0, 2);
    beat(0, 0); expect_o("t1_b2", 1, 0, 0, 0, 0, 1);
    beat(1, 1); expect_o("t1_done", 0, 1, 0, 0, 1, 0);
    tick();     expect_o("t1_hold", 0, 0, 0, 0, 1, 0);

    // 2: 7 vs 5 -> greater, decided on beat 2
    pulse_start();
    expect_o("t2_start", 1, 0, 0, 0, 0, 3);
    beat(1, 1); expect_o("t2_b1", 1, 0, 0, 0, 0, 2);
    beat(1, 0); expect_o("t2_b2", 1, 0, 0, 0, 0, 1);
    beat(1, 1); expect_o("t2_done", 0, 1, 0, 1, 0, 0);
    tick();     expect_o("t2_hold", 0, 0, 0, 1, 0, 0);

    // 3: 5 vs 7 with two idle cycles between beats -> lesser
    pulse_start();
    beat(1, 1); expect_o("t3_b1", 1, 0, 0, 0, 0, 2);
    tick();     expect_o("t3_gap1", 1, 0, 0, 0, 0, 2);
    tick();     expect_o("t3_gap2", 1, 0, 0, 0, 0, 2);
    beat(0, 1); expect_o("t3_b2", 1, 0, 0, 0, 0, 1);
    beat(1, 1); expect_o("t3_done", 0, 1, 1, 0, 0, 0);
    // bit_valid while idle is ignored
    beat(1, 0); expect_o("t3_idle_bv1", 0, 0, 1, 0, 0, 0);
    beat(0, 1); expect_o("t3_idle_bv2", 0, 0, 1, 0, 0, 0);

    // 4: partial compare discarded by restart, then 2 vs 3 -> lesser
    pulse_start();
    expect_o("t4_start_clears", 1, 0, 0, 0, 0, 3);
    beat(1, 0); expect_o("t4_partial", 1, 0, 0, 0, 0, 2);
    // restart with a valid bit on the same cycle: that bit must be ignored
    start = 1'b1; bit_valid = 1'b1; a_bit = 1'b1; b_bit = 1'b0;
    tick();
    start = 1'b0; bit_valid = 1'b0; a_bit = 1'b0; b_bit = 1'b0;
    expect_o("t4_restart", 1, 0, 0, 0, 0, 3);
    beat(0, 0); expect_o("t4_b1", 1, 0, 0, 0, 0, 2);
    beat(1, 1); expect_o("t4_b2", 1, 0, 0, 0, 0, 1);
    beat(0, 1); expect_o("t4_done", 0, 1, 1, 0, 0, 0);

    // 5: reset mid-shift (with start asserted too: reset wins), then 6 vs 6
    pulse_start();
    beat(1, 0);
    beat(0, 1); expect_o("t5_mid", 1, 0, 0, 0, 0, 1);
    rst_n = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    expect_o("t5_reset", 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    tick();     expect_o("t5_idle", 0, 0, 0, 0, 0, 0);
    pulse_start();
    beat(1, 1);
    beat(1, 1);
    beat(0, 0); expect_o("t5_done", 0, 1, 0, 0, 1, 0);

    // 6: A=101, B=011
    pulse_start();
    beat(1, 0);
    beat(0, 1);
    beat(1, 1);
`ifdef CMP_SIGNED_EN
    expect_o("t6_done_signed", 0, 1, 1, 0, 0, 0);
`else
    expect_o("t6_done_unsigned", 0, 1, 0, 1, 0, 0);
`endif
    // start during the DONE cycle restarts, then 0 vs 1 -> lesser
    pulse_start();
    expect_o("t7_restart_in_done", 1, 0, 0, 0, 0, 3);
    beat(0, 0);
    beat(0, 0);
    beat(0, 1); expect_o("t7_done", 0, 1, 1, 0, 0, 0);
    tick();     expect_o("t7_hold", 0, 0, 1, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
